sysid_arbiter: RTL and testbench

SYSID_ARBITER -- requirements
Module: sysid_arbiter

---
 rtl/sysid_arb_pkg.sv | 7 +
 rtl/sysid_arb_pick.sv | 9 +
 rtl/sysid_arbiter.sv | 94 +++++++++
 tb/tb_sysid_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/sysid_arb_pkg.sv
// sysid_arb_pkg: shared types and constants for the two-master sysid arbiter
package sysid_arb_pkg;
    localparam int DATA_W_DEFAULT = 32;
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;
    typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;
endpackage

// File: rtl/sysid_arb_pick.sv
// sysid_arb_pick: 2-way winner selection, one-hot or zero grant
module sysid_arb_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // on a tie the master other than last_grant wins; a lone request wins outright
    always_comb grant = (&req) ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/sysid_arbiter.sv
// sysid_arbiter: shares one sysid control slave between two read masters.
// SYSID_ARB_ROUND_ROBIN_EN selects round-robin; default build is fixed priority to master 0.
module sysid_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              m0_read,
    input  logic              m0_address,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic              m1_read,
    input  logic              m1_address,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              s_address,
    input  logic [DATA_W-1:0] s_readdata
);
    state_t state, state_nx;
    logic addr, id, accept, last_grant;
    logic [1:0] grant;
    logic [DATA_W-1:0] data;

`ifdef SYSID_ARB_ROUND_ROBIN_EN
    // remember the most recent winner so the other master wins the next tie
    always_ff @(posedge clock) begin
        if (!reset_n) last_grant <= 1'b1;
        else if (accept) last_grant <= grant[1];
    end
`else
    assign last_grant = 1'b1;
`endif

    sysid_arb_pick u_pick (
        .req        ({m1_read, m0_read}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // state register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // latch winner and address on accept, capture slave data in CAPTURE
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr <= ADDR_ID;
            id   <= 1'b0;
            data <= '0;
        end else begin
            if (accept) begin
                addr <= (grant[1] ? m1_address : m0_address) == ADDR_TS;
                id   <= grant[1];
            end
            if (state == CAPTURE) data <= s_readdata;
        end
    end

    // next state and per-state outputs
    always_comb begin
        state_nx         = state;
        accept           = 1'b0;
        s_address        = ADDR_ID;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        case (state)
            IDLE: if (|grant) begin
                state_nx = CAPTURE;
                accept   = 1'b1;
            end
            CAPTURE: begin
                state_nx  = RESP;
                s_address = addr;
            end
            RESP: begin
                state_nx         = IDLE;
                m0_readdatavalid = reset_n && !id;
                m1_readdatavalid = reset_n && id;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m0_waitrequest = !(reset_n && accept && grant[0]);
    assign m1_waitrequest = !(reset_n && accept && grant[1]);
    assign m0_readdata    = data;
    assign m1_readdata    = data;
endmodule

// File: tb/tb_sysid_arbiter.sv
// tb_sysid_arbiter: directed and random stimulus against a transaction-level model
module tb_sysid_arbiter;
    import sysid_arb_pkg::*;
    localparam logic [31:0] TS = 32'h50A5_D491;
`ifdef SYSID_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clock = 1'b0, reset_n = 1'b0;
    logic m0_read = 1'b0, m0_address = 1'b0, m1_read = 1'b0, m1_address = 1'b0;
    logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid, s_address;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    int n_vec = 0, n_err = 0;
    // model: cycles since last acceptance (1 = capture, 2 = response, <1 or >=3 idle)
    int age = -1, who = 0, lastg = 1, last_w = -1;
    bit addr_l = 1'b0;
    logic [31:0] data_m = 32'h0;

    always #5 clock = ~clock;

    assign s_readdata = (s_address == ADDR_TS) ? TS : 32'h0;

    sysid_arbiter #(.DATA_W(32)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .m0_read          (m0_read),
        .m0_address       (m0_address),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdatavalid (m0_readdatavalid),
        .m0_readdata      (m0_readdata),
        .m1_read          (m1_read),
        .m1_address       (m1_address),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdatavalid (m1_readdatavalid),
        .m1_readdata      (m1_readdata),
        .s_address        (s_address),
        .s_readdata       (s_readdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r0, input bit a0, input bit r1, input bit a1, input bit rn);
        int w;
        bit idle;
        m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1; reset_n = rn;
        @(negedge clock);
        idle = (age < 1) || (age >= 3);
        w = -1;
        if (rn && idle && (r0 || r1))
            w = (r0 && r1) ? ((RR && lastg == 0) ? 1 : 0) : (r0 ? 0 : 1);
        check("m0_waitrequest", 32'(m0_waitrequest), 32'(w != 0));
        check("m1_waitrequest", 32'(m1_waitrequest), 32'(w != 1));
        check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(rn && age == 2 && who == 0));
        check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(rn && age == 2 && who == 1));
        check("s_address", 32'(s_address), 32'((age == 1) ? addr_l : 1'b0));
        check("m0_readdata", m0_readdata, data_m);
        check("m1_readdata", m1_readdata, data_m);
        @(posedge clock);
        if (!rn) begin
            age = -1; data_m = 32'h0; addr_l = 1'b0; lastg = 1;
        end else begin
            if (age == 1) data_m = addr_l ? TS : 32'h0;
            if (w >= 0) begin
                age = 1; who = w; addr_l = (w == 1) ? a1 : a0;
                if (RR) lastg = w;
            end else if (age >= 1 && age < 3) age++;
        end
        last_w = w;
        #1;
    endtask

    initial begin
        bit q0, q1, b0, b1;
        q0 = 1'b0; q1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        repeat (2) cyc(1, 1, 1, 1, 0);
        // lone m0 timestamp read
        cyc(1, 1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // both masters requesting continuously
        repeat (12) cyc(1, 1, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // reset during capture of an m1 read, then a tie
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 0);
        repeat (4) cyc(1, 0, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // m1 requests during the response of an m0 read
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 1);
        // m0 withdraws while m1 is being served
        cyc(0, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 1);
        // random traffic: requests held until accepted, occasional withdraw and reset
        for (int i = 0; i < 400; i++) begin
            if (!q0 && 1'($urandom)) begin q0 = 1'b1; b0 = 1'($urandom); end
            if (!q1 && 1'($urandom)) begin q1 = 1'b1; b1 = 1'($urandom); end
            if (q0 && $urandom_range(0, 15) == 0) q0 = 1'b0;
            if (q1 && $urandom_range(0, 15) == 0) q1 = 1'b0;
            cyc(q0, b0, q1, b1, $urandom_range(0, 39) != 0);
            if (last_w == 0) q0 = 1'b0;
            if (last_w == 1) q1 = 1'b0;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
